// File: rtl/simple_circuit_exerciser.sv
// Built-in exerciser for the three-input logic circuit x = (A & B) | ~C, y = ~C.
// It walks all eight A/B/C vectors and holds each one for a programmable settle time.
// It then samples the returned x/y and records which vectors disagree with the golden function.
//
// Handshake: start is a level-sampled request that is honoured only in IDLE or DONE.
// While busy, start is ignored and is never queued. abort cancels a run and beats start.
// rst beats everything.
// SETTLE_CYCLES must be in the range 1..15. A value of 0 is not a legal configuration.
module simple_circuit_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] abc_out,
    input  logic       x_in,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The counter counts down to zero, so WAIT lasts exactly SETTLE_CYCLES cycles.
    localparam logic [3:0] LP_RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_abc, w_abc_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_pass, w_pass_nxt;
    logic [3:0] r_err, w_err_nxt;
    logic [7:0] r_fail, w_fail_nxt;

    logic       w_exp_x, w_exp_y, w_miss;
    logic [3:0] w_err_upd;

    // Golden response for the vector currently on the pins, and this vector's error tally.
    always_comb begin
        w_exp_x   = (r_abc[0] & r_abc[1]) | ~r_abc[2];
        w_exp_y   = ~r_abc[2];
        w_miss    = (x_in != w_exp_x) || (y_in != w_exp_y);
        w_err_upd = w_miss ? (r_err + 4'd1) : r_err;
    end

    // Next-state logic plus the next values of every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_abc_nxt   = r_abc;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_WAIT;
                    w_idx_nxt   = 3'd0;
                    w_abc_nxt   = 3'd0;
                    w_cnt_nxt   = LP_RELOAD;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_err_nxt   = 4'd0;
                    w_fail_nxt  = 8'd0;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_abc_nxt   = 3'd0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_CHECK: begin
                // An abort on the check edge discards that vector's result.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_abc_nxt   = 3'd0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                end else begin
                    w_err_nxt = w_err_upd;
                    if (w_miss) begin
                        w_fail_nxt[r_idx] = 1'b1;
                    end
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_DONE;
                        w_abc_nxt   = 3'd0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_upd == 4'd0);
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_idx_nxt   = r_idx + 3'd1;
                        w_abc_nxt   = r_idx + 3'd1;
                        w_cnt_nxt   = LP_RELOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 4'd0;
            r_abc   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 4'd0;
            r_fail  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_abc   <= w_abc_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    assign abc_out     = r_abc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign err_count   = r_err;
    assign fail_vec    = r_fail;
    assign o_dbg_state = r_state;

endmodule

// File: doc/simple_circuit_exerciser.md
# simple_circuit_exerciser

Built-in exerciser for the three-input simple logic circuit (x = (A & B) | ~C, y = ~C). On a start request it drives all eight A/B/C combinations onto the circuit's inputs in order, waits a programmable settle time, samples the returned x/y, and compares them against the golden function. It records per-vector failures and raises a pass/done summary. It sits on the driving side of the circuit's pins, wired to ui_in[2:0] and uo_out[1:0].

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before sampling; legal range 1..15, and 0 is illegal.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request, level-sampled; honoured only in IDLE or DONE.
- abort  in  1  cancels a run in progress; ignored outside WAIT/CHECK.
- abc_out  out  3  drive to the circuit: bit0=A, bit1=B, bit2=C.
- x_in  in  1  circuit output x.
- y_in  in  1  circuit output y.
- busy  out  1  high in WAIT and CHECK.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count == 0; low otherwise.
- err_count  out  4  number of failing vectors, 0..8.
- fail_vec  out  8  bit i set when vector i mismatched.

## Operation
- States:
  - IDLE, WAIT, CHECK, DONE. Reset and abort go to IDLE.
- Vector index idx (3 bits): abc_out = idx, so C is the MSB.
- Expected values: exp_x = (A & B) | ~C and exp_y = ~C, computed from the registered abc_out.
- IDLE/DONE + start:
  - clear err_count, fail_vec, done and pass;
  - set idx = 0 and abc_out = 0;
  - load the settle counter;
  - go to WAIT.
- WAIT: hold abc_out for exactly SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (one cycle):
  - sample x_in and y_in;
  - if x_in != exp_x or y_in != exp_y, set fail_vec[idx] and increment err_count;
  - if idx == 7, go to DONE with abc_out = 0;
  - otherwise idx and abc_out advance to idx+1, the counter reloads, and the block goes to WAIT.
- DONE:
  - done = 1, and pass = (err_count == 0) including that cycle's final update;
  - results hold until the next start or rst.
- start while busy: ignored. No queuing; the run in progress is unaffected.
- abort in WAIT/CHECK:
  - next state IDLE, abc_out = 0, busy = 0, done = 0, pass = 0;
  - err_count and fail_vec keep partial results;
  - a CHECK coinciding with abort is discarded, so nothing is recorded for that vector.
- abort and start asserted together in WAIT/CHECK: abort wins, start is ignored.
- rst dominates everything.
- One failure per vector at most, so err_count never exceeds 8 and needs no saturation.

## Timing
- Reset values: abc_out = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_vec = 0, state IDLE, idx = 0.
- All outputs are registered. Inputs x_in/y_in are sampled only on the CHECK edge and need no synchroniser; the circuit is combinational on the same clock.
- Edge numbering: start is sampled high at edge k.
  - busy = 1 from edge k.
  - Vector i is presented from edge k + i·(S+1) and held for S+1 cycles, where S = SETTLE_CYCLES.
  - Vector i is sampled at edge k + i·(S+1) + S + 1, which is the edge ending its CHECK cycle.
  - done = 1 and busy = 0 from edge k + 8·(S+1). With S = 2 this is 24 edges after start.
- start held continuously high:
  - DONE lasts exactly one cycle, then a new run begins;
  - done pulses for one cycle per run.
- rst asserted mid-run: all outputs equal the reset values after that edge, and nothing completes.

## Test plan
- Golden model wired, S=2, one-cycle start pulse: abc_out steps 0,1,…,7 with each value held 3 cycles. Then done=1 at start+24, pass=1, err_count=0, fail_vec=8'h00, abc_out=0.
- x_in tied 0: fail_vec=8'h8F (vectors 0–3 and 7), err_count=5, pass=0, done at start+24.
- y_in = abc_out[2] (inverted y): fail_vec=8'hFF, err_count=8, pass=0.
- start re-pulsed at cycle 5 of a run: no restart, and done still at start+24. start pulsed again in DONE after the x-stuck test: err_count and fail_vec clear to 0, busy=1 next cycle, and the golden run ends with pass=1.
- rst asserted at cycle 10 of a run: on the next cycle all outputs are 0 and the state is IDLE, with no done afterward. Repeat with abort at cycle 10 under x stuck 0: busy=0, done=0, fail_vec=8'h07 and err_count=3 retained (vectors 0–2 checked by cycle 9).
- S=1 golden run: each vector is held 2 cycles, and done arrives at start+16 with pass=1.
